// File: rtl/f_register_file.sv
// RV32F floating-point register file with fcsr state and a busy scoreboard.
// Feeds operands and the resolved rounding mode to the FPU and stalls issue.
module f_register_file #(
  parameter int NUM_REGS = 32,
  parameter int WIDTH    = 32,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    f_rs1,
  input  logic [AW-1:0]    f_rs2,
  output logic [WIDTH-1:0] f_rs1_data,
  output logic [WIDTH-1:0] f_rs2_data,
  input  logic [AW-1:0]    f_rd,
  input  logic             f_wen,
  input  logic [WIDTH-1:0] f_w_data,
  input  logic             f_NV,
  input  logic             f_DZ,
  input  logic             f_OF,
  input  logic             f_UF,
  input  logic             f_NX,
  input  logic [2:0]       f_frm_in,
  output logic [2:0]       f_frm_out,
  output logic             frm_illegal,
  output logic [4:0]       f_flags,
  input  logic [1:0]       csr_addr,
  input  logic             csr_wen,
  input  logic [7:0]       csr_wdata,
  output logic [7:0]       csr_rdata,
  input  logic             issue_valid,
  input  logic [AW-1:0]    issue_rd,
  output logic             stall
);

  logic [WIDTH-1:0]    r_regs [NUM_REGS];
  logic [4:0]          r_fflags;
  logic [2:0]          r_frm;
  logic [NUM_REGS-1:0] r_busy;

  logic [NUM_REGS-1:0] w_wb_mask;
  logic [NUM_REGS-1:0] w_eff_busy;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic [4:0]          w_fpu_flags;
  logic                w_csr_flags;
  logic                w_csr_frm;

  assign w_fpu_flags = {f_NV, f_DZ, f_OF, f_UF, f_NX};
  assign w_csr_flags = csr_wen &&
    (csr_addr == 2'd1 || csr_addr == 2'd3);
  assign w_csr_frm   = csr_wen &&
    (csr_addr == 2'd2 || csr_addr == 2'd3);

  always_comb begin
    w_wb_mask = '0;
    if (f_wen) w_wb_mask[f_rd] = 1'b1;
  end

  // A writeback this cycle releases the hazard on its rd.
  assign w_eff_busy = r_busy & ~w_wb_mask;

  assign stall = issue_valid &&
    (w_eff_busy[f_rs1] || w_eff_busy[f_rs2] ||
     w_eff_busy[issue_rd]);

  // Set after clear: a newly issued op owns rd.
  always_comb begin
    w_busy_nxt = r_busy & ~w_wb_mask;
    if (issue_valid && !stall) w_busy_nxt[issue_rd] = 1'b1;
  end

  assign f_rs1_data = (f_wen && f_rd == f_rs1) ?
    f_w_data : r_regs[f_rs1];
  assign f_rs2_data = (f_wen && f_rd == f_rs2) ?
    f_w_data : r_regs[f_rs2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (f_wen) begin
      r_regs[f_rd] <= f_w_data;
    end
  end

  // CSR writes to fflags override same-cycle accumulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fflags <= '0;
    end else if (w_csr_flags) begin
      r_fflags <= csr_wdata[4:0];
    end else if (f_wen) begin
      r_fflags <= r_fflags | w_fpu_flags;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frm <= 3'd0;
    end else if (w_csr_frm) begin
      r_frm <= csr_wdata[7:5] & {3{csr_addr == 2'd3}} |
               csr_wdata[2:0] & {3{csr_addr == 2'd2}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_nxt;
  end

  assign f_flags     = r_fflags;
  assign f_frm_out   = (f_frm_in == 3'b111) ? r_frm : f_frm_in;
  assign frm_illegal = (f_frm_out >= 3'd5);

  always_comb begin
    csr_rdata = 8'h00;
    unique case (csr_addr)
      2'd0: csr_rdata = 8'h00;
      2'd1: csr_rdata = {3'b000, r_fflags};
      2'd2: csr_rdata = {5'b00000, r_frm};
      2'd3: csr_rdata = {r_frm, r_fflags};
    endcase
  end

endmodule

// File: tb/tb_f_register_file.sv
// Randomized bench for f_register_file against an array-based model.
// Directed scenarios first, then random traffic with occasional resets.
module tb_f_register_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  f_rs1, f_rs2, f_rd, issue_rd;
  logic [31:0] f_rs1_data, f_rs2_data, f_w_data;
  logic        f_wen, f_NV, f_DZ, f_OF, f_UF, f_NX;
  logic [2:0]  f_frm_in, f_frm_out;
  logic        frm_illegal;
  logic [4:0]  f_flags;
  logic [1:0]  csr_addr;
  logic        csr_wen;
  logic [7:0]  csr_wdata, csr_rdata;
  logic        issue_valid, stall;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_regs [32];
  logic [4:0]  m_flags;
  logic [2:0]  m_frm;
  bit          m_busy [32];

  f_register_file dut (
    .clk(clk), .rst(rst),
    .f_rs1(f_rs1), .f_rs2(f_rs2),
    .f_rs1_data(f_rs1_data), .f_rs2_data(f_rs2_data),
    .f_rd(f_rd), .f_wen(f_wen), .f_w_data(f_w_data),
    .f_NV(f_NV), .f_DZ(f_DZ), .f_OF(f_OF),
    .f_UF(f_UF), .f_NX(f_NX),
    .f_frm_in(f_frm_in), .f_frm_out(f_frm_out),
    .frm_illegal(frm_illegal), .f_flags(f_flags),
    .csr_addr(csr_addr), .csr_wen(csr_wen),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit hazard(logic [4:0] i);
    return m_busy[i] && !(f_wen && f_rd == i);
  endfunction

  function automatic bit exp_stall();
    return issue_valid &&
      (hazard(f_rs1) || hazard(f_rs2) || hazard(issue_rd));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_flags = '0;
    m_frm   = '0;
  endtask

  task automatic check_outputs();
    logic [31:0] e1, e2;
    logic [2:0]  erm;
    logic [7:0]  ecsr;
    e1  = (f_wen && f_rd == f_rs1) ? f_w_data : m_regs[f_rs1];
    e2  = (f_wen && f_rd == f_rs2) ? f_w_data : m_regs[f_rs2];
    erm = (f_frm_in == 3'd7) ? m_frm : f_frm_in;
    case (csr_addr)
      2'd1:    ecsr = {3'b0, m_flags};
      2'd2:    ecsr = {5'b0, m_frm};
      2'd3:    ecsr = {m_frm, m_flags};
      default: ecsr = 8'h00;
    endcase
    check("rs1_data", f_rs1_data, e1);
    check("rs2_data", f_rs2_data, e2);
    check("frm_out", 32'(f_frm_out), 32'(erm));
    check("frm_illegal", 32'(frm_illegal),
          32'(erm == 5 || erm == 6 || erm == 7));
    check("flags", 32'(f_flags), 32'(m_flags));
    check("csr_rdata", 32'(csr_rdata), 32'(ecsr));
    check("stall", 32'(stall), 32'(exp_stall()));
  endtask

  task automatic model_update();
    bit st;
    st = exp_stall();
    if (f_wen) begin
      m_regs[f_rd] = f_w_data;
      m_flags |= {f_NV, f_DZ, f_OF, f_UF, f_NX};
      m_busy[f_rd] = 1'b0;
    end
    if (csr_wen && (csr_addr == 1 || csr_addr == 3))
      m_flags = csr_wdata[4:0];
    if (csr_wen && csr_addr == 2) m_frm = csr_wdata[2:0];
    if (csr_wen && csr_addr == 3) m_frm = csr_wdata[7:5];
    if (issue_valid && !st) m_busy[issue_rd] = 1'b1;
  endtask

  task automatic settle();
    #4;
    check_outputs();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    f_rs1 = 0; f_rs2 = 0; f_rd = 0; issue_rd = 0;
    f_wen = 0; f_w_data = 0;
    {f_NV, f_DZ, f_OF, f_UF, f_NX} = '0;
    f_frm_in = 0; csr_addr = 0; csr_wen = 0; csr_wdata = 0;
    issue_valid = 0;
  endtask

  // Assert reset mid-cycle; outputs must clear at once.
  task automatic mid_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check_outputs();
    check("rst_stall", 32'(stall), 32'd0);
    for (int a = 0; a < 4; a++) begin
      csr_addr = 2'(a);
      #0.1;
      check("rst_csr", 32'(csr_rdata), 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    csr_addr = 3;
    settle();
    check("reset_csr", 32'(csr_rdata), 32'd0);
    check("reset_flags", 32'(f_flags), 32'd0);
    tick();

    idle();
    f_wen = 1; f_rd = 5; f_w_data = 32'h3F800000;
    f_rs1 = 5; f_rs2 = 6;
    settle();
    check("bypass", f_rs1_data, 32'h3F800000);
    check("rs2_zero", f_rs2_data, 32'd0);
    tick();
    f_wen = 0;
    settle();
    check("array", f_rs1_data, 32'h3F800000);
    tick();

    idle();
    f_wen = 1; f_rd = 1; f_NX = 1;
    settle(); tick();
    f_NX = 0; f_OF = 1; f_rd = 2;
    settle(); tick();
    idle();
    csr_addr = 3;
    settle();
    check("accum_flags", 32'(f_flags), 32'h05);
    check("accum_fcsr", 32'(csr_rdata), 32'h05);
    tick();

    idle();
    csr_wen = 1; csr_addr = 1; csr_wdata = 0;
    f_wen = 1; f_rd = 4; f_NV = 1;
    settle(); tick();
    idle();
    settle();
    check("csr_prio", 32'(f_flags), 32'd0);
    tick();

    idle();
    csr_wen = 1; csr_addr = 2; csr_wdata = 8'h02;
    settle(); tick();
    idle();
    f_frm_in = 3'b111;
    settle();
    check("dyn_rm", 32'(f_frm_out), 32'd2);
    check("dyn_legal", 32'(frm_illegal), 32'd0);
    tick();
    csr_wen = 1; csr_addr = 2; csr_wdata = 8'h06;
    settle(); tick();
    csr_wen = 0;
    settle();
    check("dyn_illegal", 32'(frm_illegal), 32'd1);
    tick();
    f_frm_in = 3'b001;
    settle();
    check("static_rm", 32'(f_frm_out), 32'd1);
    tick();

    idle();
    issue_valid = 1; issue_rd = 3;
    settle();
    check("issue_free", 32'(stall), 32'd0);
    tick();
    issue_rd = 10; f_rs1 = 3;
    settle();
    check("raw_stall", 32'(stall), 32'd1);
    tick();
    f_wen = 1; f_rd = 3; f_w_data = 32'h40000000;
    settle();
    check("wb_release", 32'(stall), 32'd0);
    tick();
    idle();
    issue_valid = 1; issue_rd = 11; f_rs1 = 3;
    settle();
    check("busy3_clear", 32'(stall), 32'd0);
    tick();

    idle();
    issue_valid = 1; issue_rd = 7;
    f_wen = 1; f_rd = 7; f_w_data = 32'h12345678;
    settle(); tick();
    idle();
    issue_valid = 1; issue_rd = 12; f_rs1 = 7;
    settle();
    check("set_wins", 32'(stall), 32'd1);
    mid_reset();
    settle();
    check("post_rst_stall", 32'(stall), 32'd0);
    tick();

    for (int n = 0; n < 1500; n++) begin
      idle();
      f_rs1 = 5'($urandom_range(0, 7));
      f_rs2 = 5'($urandom_range(0, 7));
      f_rd = 5'($urandom_range(0, 7));
      issue_rd = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) f_rs1 = 5'($urandom);
      if ($urandom_range(0, 3) == 0) f_rd = 5'($urandom);
      f_wen = ($urandom_range(0, 9) < 4);
      f_w_data = $urandom;
      {f_NV, f_DZ, f_OF, f_UF, f_NX} = 5'($urandom);
      if ($urandom_range(0, 2) != 0)
        {f_NV, f_DZ, f_OF, f_UF, f_NX} = '0;
      f_frm_in = 3'($urandom);
      csr_addr = 2'($urandom);
      csr_wen = ($urandom_range(0, 9) == 0);
      csr_wdata = 8'($urandom);
      issue_valid = ($urandom_range(0, 9) < 4);
      settle();
      if ($urandom_range(0, 199) == 0) mid_reset();
      else tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/f_register_file.md
# f_register_file

Floating-point architectural state for the RV32F datapath: 32 x 32-bit FP registers, the fcsr (fflags, frm), and a busy-register scoreboard for multi-cycle FPU operations. Sits directly downstream of the FPU: it consumes the FPU result, write enable and exception flags, and feeds operands and the resolved rounding mode back to the FPU. It also gives the CSR unit read/write access to fflags, frm and fcsr, and gives the issue stage a hazard-stall signal.

## Interface
- NUM_REGS, 32, number of FP registers (index width is log2(NUM_REGS)=5)
- WIDTH, 32, FP register width
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- f_rs1, f_rs2  in  5  read indices
- f_rs1_data, f_rs2_data  out  WIDTH  read data (combinational, write-through bypassed)
- f_rd  in  5  writeback index
- f_wen  in  1  writeback strobe; also qualifies the flags
- f_w_data  in  WIDTH  writeback data (FPU result or FLW data)
- f_NV, f_DZ, f_OF, f_UF, f_NX  in  1 each  exception flags of the op being written back
- f_frm_in  in  3  instruction rm field
- f_frm_out  out  3  resolved rounding mode to the FPU
- frm_illegal  out  1  resolved rm is 5, 6 or 7
- f_flags  out  5  current fflags {NV,DZ,OF,UF,NX} = [4:0]
- csr_addr  in  2  0 = none, 1 = fflags, 2 = frm, 3 = fcsr
- csr_wen  in  1  CSR write strobe
- csr_wdata  in  8  CSR write data
- csr_rdata  out  8  CSR read data
- issue_valid  in  1  a multi-cycle FP op is issuing this cycle
- issue_rd  in  5  destination of the issuing op
- stall  out  1  issue must hold this cycle

## Operation
- Registers: f0 is a normal register (not hardwired to zero). On f_wen, regs[f_rd] <= f_w_data.
- Read bypass: if f_wen and f_rd == f_rsN, f_rsN_data = f_w_data; otherwise regs[f_rsN].
- Flag accumulation: on f_wen, fflags <= fflags | {f_NV,f_DZ,f_OF,f_UF,f_NX}. Flags are sticky.
- CSR read, combinational:
  - addr 1 -> {3'b0, fflags}
  - addr 2 -> {5'b0, frm}
  - addr 3 -> {frm, fflags}
  - addr 0 -> 8'h00
- CSR write (csr_wen):
  - addr 1 -> fflags <= wdata[4:0]
  - addr 2 -> frm <= wdata[2:0]
  - addr 3 -> both, from wdata[7:5] and wdata[4:0]
  - addr 0 -> no effect
- CSR/FPU collision: a CSR write to fflags in the same cycle as f_wen takes priority; the accumulated flags of that cycle are discarded.
- Rounding mode: f_frm_out = frm when f_frm_in == 3'b111 (dynamic), else f_frm_in.
- frm_illegal = (f_frm_out inside {5,6,7}). This includes dynamic mode with frm holding an illegal value.
- Scoreboard: busy[31:0].
  - issue_valid && !stall sets busy[issue_rd].
  - f_wen clears busy[f_rd].
  - If the same index is both set and cleared in one cycle, set wins: the new op owns rd.
- Stall = issue_valid && (eff_busy[f_rs1] || eff_busy[f_rs2] || eff_busy[issue_rd]).
  - eff_busy[i] = busy[i] && !(f_wen && f_rd == i), so a same-cycle writeback releases the hazard.
  - Stall is combinational. While stall is high, issue_valid does not set busy.

## Timing
- Reset (async, immediate):
  - all regs = 0, fflags = 0, frm = 0 (RNE), busy = 0
  - outputs follow: f_flags = 0, csr_rdata = 0 for any addr, stall = 0
  - f_rsN_data = 0 unless bypassed
- Reset mid-operation clears busy. Any writeback arriving after reset deassertion still writes the register and flags normally.
- Write latency: 1 cycle to the array, 0 cycles via bypass. A value written at edge N is readable from the array after edge N.
- Flag/CSR updates are visible on f_flags and csr_rdata in the cycle after the edge.
- Dynamic rm uses frm as registered. A CSR write to frm in cycle N affects f_frm_out from cycle N+1.

## Test plan
- Reset, then f_wen with f_rd=5, f_w_data=32'h3F800000 -> same cycle f_rs1=5 reads 3F800000 (bypass); next cycle the array read gives 3F800000. f_rs2=6 reads 0.
- Two writebacks, first with f_NX=1, then with f_OF=1 -> f_flags=5'b00101. csr_addr=3 reads 8'h05.
- csr_wen addr=1 wdata=0 in the same cycle as f_wen with f_NV=1 -> f_flags=0 next cycle (CSR priority).
- csr_wen addr=2 wdata=3'b010, then f_frm_in=111 -> f_frm_out=010, frm_illegal=0. Write frm=6 with dynamic rm -> frm_illegal=1. f_frm_in=001 -> f_frm_out=001.
- Issue rd=3, then issue with rs1=3 -> stall=1. Writeback f_rd=3 in the stalled cycle -> stall=0 that cycle and busy[3] clears.
- Same-cycle issue rd=7 and writeback f_rd=7 (7 previously free) -> busy[7]=1 afterward. Assert rst mid-flight -> busy=0, stall=0 immediately.
